// File: rtl/pwm_duty_pkg.sv
// Shared types and helpers for the PWM duty generator and its prescaler.
package pwm_duty_pkg;

    localparam int DUTY_W = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        RUN       = 2'd2
    } state_e;

    // Limit a duty request to the period length; a 128-tick period can never clamp a 7-bit duty.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                     input int unsigned       period);
        logic [7:0] p8;
        p8 = 8'(period);
        return ({1'b0, duty} > p8) ? p8[DUTY_W-1:0] : duty;
    endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// Clock prescaler: tick_o is high on the last clk of every PRESC-cycle group.
module pwm_tick_div #(
    parameter int unsigned PRESC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] presc_cnt_q;

    assign tick_o = (presc_cnt_q == PW'(PRESC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_generator.sv
// PWM generator with period-boundary duty reload, soft-start ramp and per-period strobe.
module pwm_duty_generator
    import pwm_duty_pkg::*;
#(
    parameter int unsigned PERIOD = 64,
    parameter int unsigned PRESC  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_out_o,
    output logic              period_start_o,
    output logic [DUTY_W-1:0] duty_applied_o,
    output logic              ss_active_o
);

    localparam int CW = $clog2(PERIOD);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DUTY_W-1:0] applied_q, applied_d;
    logic              pwm_q, pwm_d;
    logic              start_q, start_d;
    logic              ss_q;

    logic              tick_raw;
    logic              tick;
    logic              presc_clr;
    logic              boundary;
    logic [DUTY_W-1:0] target;

    assign presc_clr = !en_i || (state_q == IDLE);

    pwm_tick_div #(
        .PRESC(PRESC)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .clr_i (presc_clr),
        .tick_o(tick_raw)
    );

    assign tick     = tick_raw && (state_q != IDLE);
    assign boundary = tick && (cnt_q == CW'(PERIOD - 1));
    assign target   = clamp_duty(duty_i, PERIOD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        applied_d = applied_q;
        start_d   = 1'b0;
        if (!en_i) begin
            // Disable wins over a coincident boundary; the running period is abandoned.
            state_d   = IDLE;
            cnt_d     = '0;
            applied_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SOFTSTART;
                    cnt_d     = '0;
                    applied_d = '0;
                    start_d   = 1'b1;
                end
                SOFTSTART, RUN: begin
                    if (boundary) begin
                        cnt_d   = '0;
                        start_d = 1'b1;
                        if (state_q == RUN) begin
                            applied_d = target;
                        end else if (({1'b0, applied_q} + 8'd1) >= {1'b0, target}) begin
                            applied_d = target;
                            state_d   = RUN;
                        end else begin
                            applied_d = applied_q + DUTY_W'(1);
                        end
                    end else if (tick) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    applied_d = '0;
                end
            endcase
        end
        // Next-state compare keeps pwm aligned with cnt, so full duty has no wrap glitch.
        pwm_d = (state_d != IDLE) && (8'(cnt_d) < {1'b0, applied_d});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            applied_q <= '0;
            pwm_q     <= 1'b0;
            start_q   <= 1'b0;
            ss_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
            pwm_q     <= pwm_d;
            start_q   <= start_d;
            ss_q      <= (state_d == SOFTSTART);
        end
    end

    assign pwm_out_o      = pwm_q;
    assign period_start_o = start_q;
    assign duty_applied_o = applied_q;
    assign ss_active_o    = ss_q;

endmodule

// File: tb/tb_pwm_duty_generator.sv
// Bench for pwm_duty_generator: two configurations against a clk-level behavioural model.
module tb_pwm_duty_generator;

    logic       clk;
    logic       rst_b;
    logic       en_a, en_b;
    logic [6:0] duty_a, duty_b;
    logic       pwm_a, ps_a, ss_a, pwm_b, ps_b, ss_b;
    logic [6:0] app_a, app_b;

    int checks   = 0;
    int failures = 0;

    int hi_a[$], len_a[$], hi_b[$], len_b[$];

    pwm_duty_generator #(.PERIOD(64), .PRESC(1)) dut_a (
        .clk(clk), .reset(rst_b), .en_i(en_a), .duty_i(duty_a),
        .pwm_out_o(pwm_a), .period_start_o(ps_a), .duty_applied_o(app_a), .ss_active_o(ss_a)
    );

    pwm_duty_generator #(.PERIOD(8), .PRESC(3)) dut_b (
        .clk(clk), .reset(rst_b), .en_i(en_b), .duty_i(duty_b),
        .pwm_out_o(pwm_b), .period_start_o(ps_b), .duty_applied_o(app_b), .ss_active_o(ss_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state measured in clks since the period began, not in ticks.
    typedef struct packed {
        bit active;
        bit ss;
        bit ps;
        bit pwm;
        int pos;
        int applied;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(input mdl_t m, input bit en, input int duty,
                                  input int period, input int presc);
        mdl_t n;
        int   tgt;
        n   = m;
        tgt = (duty < period) ? duty : period;
        if (!en) begin
            n = '0;
        end else if (!m.active) begin
            n        = '0;
            n.active = 1'b1;
            n.ss     = 1'b1;
            n.ps     = 1'b1;
        end else begin
            n.pos = m.pos + 1;
            n.ps  = 1'b0;
            if (n.pos == period * presc) begin
                n.pos = 0;
                n.ps  = 1'b1;
                if (m.ss && (m.applied + 1 < tgt)) begin
                    n.applied = m.applied + 1;
                end else begin
                    n.applied = tgt;
                    n.ss      = 1'b0;
                end
            end
        end
        n.pwm = n.active && (n.pos < n.applied * presc);
        return n;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, en_a, int'(duty_a), 64, 1);
            mb <= step(mb, en_b, int'(duty_b), 8, 3);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            chk("a_pwm", int'(pwm_a), int'(ma.pwm));
            chk("a_period_start", int'(ps_a), int'(ma.ps));
            chk("a_duty_applied", int'(app_a), ma.applied);
            chk("a_ss_active", int'(ss_a), int'(ma.ss));
            chk("b_pwm", int'(pwm_b), int'(mb.pwm));
            chk("b_period_start", int'(ps_b), int'(mb.ps));
            chk("b_duty_applied", int'(app_b), mb.applied);
            chk("b_ss_active", int'(ss_b), int'(mb.ss));
        end
    end

    // Per-period high-clk count and length, pushed when the next period starts.
    initial begin
        int hi, len;
        bit run;
        hi = 0; len = 0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_b || !en_a) begin
                run = 0;
            end else if (ps_a) begin
                if (run) begin
                    hi_a.push_back(hi);
                    len_a.push_back(len);
                end
                hi = int'(pwm_a); len = 1; run = 1;
            end else if (run) begin
                hi += int'(pwm_a); len++;
            end
        end
    end

    initial begin
        int hi, len;
        bit run;
        hi = 0; len = 0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_b || !en_b) begin
                run = 0;
            end else if (ps_b) begin
                if (run) begin
                    hi_b.push_back(hi);
                    len_b.push_back(len);
                end
                hi = int'(pwm_b); len = 1; run = 1;
            end else if (run) begin
                hi += int'(pwm_b); len++;
            end
        end
    end

    task automatic wait_ps_a();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps_a) break;
        end
        chk("a_period_start_seen", int'(ps_a), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_pwm"}, int'(pwm_a), 0);
        chk({tag, "_a_ps"}, int'(ps_a), 0);
        chk({tag, "_a_applied"}, int'(app_a), 0);
        chk({tag, "_a_ss"}, int'(ss_a), 0);
        chk({tag, "_b_pwm"}, int'(pwm_b), 0);
        chk({tag, "_b_ps"}, int'(ps_b), 0);
        chk({tag, "_b_applied"}, int'(app_b), 0);
        chk({tag, "_b_ss"}, int'(ss_b), 0);
    endtask

    initial begin
        int n, nb;
        rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0; duty_a = '0; duty_b = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_b = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        // Soft-start ramp: A to 29 in 64-clk periods, B to 4 in 24-clk periods.
        duty_a = 7'd29; duty_b = 7'd4;
        en_a = 1'b1; en_b = 1'b1;
        n  = hi_a.size();
        nb = hi_b.size();
        @(negedge clk);
        chk("ramp_start_a_ps", int'(ps_a), 1);
        chk("ramp_start_a_ss", int'(ss_a), 1);
        for (int i = 0; i < 2200 && hi_a.size() < n + 31; i++) @(negedge clk);
        for (int k = 0; k < 31; k++) begin
            chk($sformatf("ramp_a_hi[%0d]", k), qget(hi_a, n + k), (k < 29) ? k : 29);
            chk($sformatf("ramp_a_len[%0d]", k), qget(len_a, n + k), 64);
        end
        chk("ramp_a_ss_done", int'(ss_a), 0);
        chk("ramp_a_applied", int'(app_a), 29);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("ramp_b_hi[%0d]", k), qget(hi_b, nb + k), 3 * ((k < 4) ? k : 4));
            chk($sformatf("ramp_b_len[%0d]", k), qget(len_b, nb + k), 24);
        end

        // Duty raised mid-period: current period unaffected, then clamped to full high.
        wait_ps_a();
        repeat (10) @(negedge clk);
        duty_a = 7'd100;
        n = hi_a.size();
        for (int i = 0; i < 300 && hi_a.size() < n + 3; i++) @(negedge clk);
        chk("dchg_cur_hi", qget(hi_a, n), 29);
        chk("dchg_next_hi", qget(hi_a, n + 1), 64);
        chk("dchg_next2_hi", qget(hi_a, n + 2), 64);
        chk("dchg_applied", int'(app_a), 64);

        // Disable mid-period while high, then re-enable into a fresh ramp.
        wait_ps_a();
        repeat (5) @(negedge clk);
        chk("drop_pwm_before", int'(pwm_a), 1);
        en_a = 1'b0;
        @(negedge clk);
        chk("drop_pwm", int'(pwm_a), 0);
        chk("drop_ps", int'(ps_a), 0);
        chk("drop_applied", int'(app_a), 0);
        en_a = 1'b1;
        n = hi_a.size();
        @(negedge clk);
        chk("reen_ss", int'(ss_a), 1);
        chk("reen_ps", int'(ps_a), 1);
        chk("reen_applied", int'(app_a), 0);
        for (int i = 0; i < 200 && hi_a.size() < n + 2; i++) @(negedge clk);
        chk("reen_hi0", qget(hi_a, n), 0);
        chk("reen_hi1", qget(hi_a, n + 1), 1);

        // Zero duty: RUN after the first boundary, never high, strobe every 64 clks.
        en_a = 1'b0; duty_a = 7'd0;
        @(negedge clk);
        en_a = 1'b1;
        n = hi_a.size();
        for (int i = 0; i < 300 && hi_a.size() < n + 3; i++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("zero_hi[%0d]", k), qget(hi_a, n + k), 0);
            chk($sformatf("zero_len[%0d]", k), qget(len_a, n + k), 64);
        end
        chk("zero_ss", int'(ss_a), 0);
        chk("zero_applied", int'(app_a), 0);

        // Random duty changes and enable toggles, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(39) == 0) duty_a = 7'($urandom_range(127));
            if ($urandom_range(29) == 0) duty_b = 7'($urandom_range(127));
            if (en_a ? ($urandom_range(299) == 0) : ($urandom_range(19) == 0)) en_a = !en_a;
            if (en_b ? ($urandom_range(199) == 0) : ($urandom_range(19) == 0)) en_b = !en_b;
        end

        // Asynchronous reset while running with pwm high.
        en_a = 1'b0; en_b = 1'b1; duty_a = 7'd10;
        @(negedge clk);
        en_a = 1'b1;
        for (int i = 0; i < 1500 && !(ss_a == 1'b0 && pwm_a == 1'b1 && app_a == 7'd10); i++)
            @(negedge clk);
        chk("rst_pre_pwm", int'(pwm_a), 1);
        chk("rst_pre_ss", int'(ss_a), 0);
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_restart_ss", int'(ss_a), 1);
        chk("rst_restart_ps", int'(ps_a), 1);
        chk("rst_restart_applied", int'(app_a), 0);
        repeat (70) @(negedge clk);
        chk("rst_restart_step", int'(app_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_duty_generator.md
Name: pwm_duty_generator

Overview:
Converts the 7-bit duty command produced by the power-regulation loop into a PWM drive waveform for the power stage. Duty is double-buffered and applied only at period boundaries. Enable starts with a soft-start ramp. A per-period strobe is emitted so the regulation loop can update once per PWM period.

Parameters:
PERIOD, 64, ticks per PWM period; legal range 2..128
PRESC, 1, clk cycles per tick; legal range 1..256; 1 = tick every clk
DUTY_W, 7, width of duty command; fixed at 7

Ports:
clk  in  1  clock
reset  in  1  reset (asynchronous, active-low)
en  in  1  output enable, level-sensitive
duty  in  7  requested high ticks per period (0..127)
pwm_out  out  1  PWM drive, registered
period_start  out  1  1-clk strobe at each period boundary
duty_applied  out  7  duty value in force for the current period
ss_active  out  1  high while soft-start ramp is in progress

Behaviour:
- Reset: every output is 0; state IDLE; prescaler, period counter cnt and applied are 0.
- Tick generator: presc_cnt counts 0..PRESC-1; tick = (presc_cnt == PRESC-1). With PRESC=1, tick is constant 1. Held at 0 in IDLE.
- target = min(duty, PERIOD). Computed combinationally, but sampled only at a boundary.
- Boundary = tick && cnt == PERIOD-1. At a boundary:
  - cnt <= 0
  - applied is reloaded (see states)
  - period_start <= 1 for exactly one clk
- Otherwise on tick: cnt <= cnt+1.
- Changes to duty between boundaries have no effect on the current period.
- pwm_out is updated on the same edge as cnt, using next-state values:
  - pwm_out <= (state_next != IDLE) && (cnt_next < applied_next)
  - Result: pwm_out is high for exactly applied ticks, starting at tick 0 of the period.
  - applied = 0 gives a constant low; applied = PERIOD gives a constant high with no glitch at the wrap.
- duty_applied = applied (registered). ss_active = (state == SOFTSTART).

States:
- IDLE: en = 1 at a clk edge
  - state <= SOFTSTART
  - cnt <= 0, presc_cnt <= 0, applied <= 0
  - period_start <= 1 (the first period begins on that edge)
- SOFTSTART, at each boundary:
  - if applied+1 >= target: applied <= target, state <= RUN
  - else: applied <= applied+1
  - If target drops below applied, the first condition fires, giving an immediate step down and entry to RUN.
- RUN, at each boundary: applied <= target.
- Any state with en = 0 at a clk edge:
  - next edge: state <= IDLE, pwm_out <= 0, period_start <= 0
  - cnt, presc_cnt and applied are cleared
  - The current period is not completed.
  - en deassert has priority over a simultaneous boundary.
- Re-enable always restarts soft-start from 0.
- Reset asserted mid-operation clears everything asynchronously, so pwm_out drops immediately.

Widths:
- cnt is $clog2(PERIOD) bits; compares against cnt+1 are done at 8 bits.
- applied is 7 bits; the clamp to PERIOD guarantees applied <= 127.
- applied+1 is computed at 8 bits, so there is no wrap.

Decomposition:
- Package pwm_duty_pkg:
  - state enum {IDLE, SOFTSTART, RUN}
  - DUTY_W localparam
  - function clamp_duty(duty, period)
- Sub-module pwm_tick_div: PRESC prescaler with synchronous clear input, output tick.
- The top module holds the FSM, cnt, shadow/applied register and the output registers.

Test Plan:
- PERIOD=64, PRESC=1, duty=29, en rises → 30 boundary-to-boundary periods during ramp:
  - pwm_out high 0,1,2,...,29 ticks per period
  - ss_active drops at the boundary where applied reaches 29
  - thereafter exactly 29 high clks per 64; period_start every 64 clks
- duty=0 then en=1 → state RUN after the first boundary; pwm_out never high; duty_applied=0; period_start still every 64 clks.
- RUN at duty=29, duty changes to 100 at cnt=10 (PERIOD=64):
  - current period still 29 high
  - next period duty_applied=64 (clamped) and pwm_out constant high across the wrap
- RUN, en drops at cnt=5 with pwm_out high → pwm_out=0, period_start=0, duty_applied=0 on the next edge; re-enable restarts the ramp at 0.
- PRESC=3, PERIOD=8, duty=4, after ramp → period 24 clks; pwm_out high 12 clks; period_start spacing 24.
- Reset asserted mid-RUN while pwm_out=1 → all outputs 0 asynchronously; after release with en=1, soft-start begins from 0.
